gemm_stream_ctrl: RTL and testbench

- Valid/ready streaming controller for the fixed-latency, non-stallable 2x2 GEMM pipeline (flattened 128-bit A/B in, 128-bit C out, no handshake of its own).
- Tracks in-flight jobs with a valid shift register and captures results into an output FIFO.
- Admits new jobs only when a FIFO slot is guaranteed, so no result is ever dropped.
- Provides a drain sequence used by the host before reconfiguration or readback.

---
 rtl/gemm_stream_ctrl.sv | 156 +++++++++++++++
 tb/tb_gemm_stream_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_stream_ctrl.sv
// gemm_stream_ctrl: valid/ready front end for a fixed-latency, non-stallable
// GEMM datapath. Jobs are tracked by a valid shift register that mirrors the
// datapath pipeline. Results land in an output FIFO. A job is admitted only
// when a FIFO slot is already reserved for its result, so nothing is dropped.
module gemm_stream_ctrl #(
  parameter  int DW    = 32,
  parameter  int N     = 2,
  parameter  int LAT   = 6,
  parameter  int DEPTH = 8,
  localparam int W     = N * N * DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] gemm_a,
  output logic [W-1:0] gemm_b,
  input  logic [W-1:0] gemm_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         drain_req,
  output logic         drain_done,
  output logic         busy,
  output logic [15:0]  done_count
);

  localparam int IW = $clog2(LAT + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LAT-1:0]  vld;
  logic [IW-1:0]   inflight_cnt;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [W-1:0]    fifo_mem [DEPTH];
  logic            fire;
  logic            push;
  logic            pop;
  logic            credit_ok;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The datapath samples operands every cycle; non-fire results are masked by vld.
  assign gemm_a = in_a;
  assign gemm_b = in_b;

  // Credit: every in-flight job already owns a FIFO slot. Registered terms only,
  // so out_ready never reaches in_ready combinationally.
  assign credit_ok = (32'(fifo_count) + 32'(inflight_cnt)) < 32'(DEPTH);

  assign fire      = in_valid && in_ready;
  assign push      = vld[LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_mem[rd_ptr];
  assign busy      = (inflight_cnt != '0) || out_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; drain_req outranks fire, and a started drain always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (drain_req) state_nxt = DRAIN;
        else if (fire) state_nxt = RUN;
      end
      RUN: begin
        if (drain_req)          state_nxt = DRAIN;
        else if (!busy && !fire) state_nxt = IDLE;
      end
      DRAIN: begin
        if (drain_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs held inactive while reset is asserted, even before any clock edge.
  always_comb begin
    in_ready   = 1'b0;
    drain_done = 1'b0;
    if (rst) begin
      in_ready   = (state != DRAIN) && credit_ok;
      drain_done = (state == DRAIN) && (inflight_cnt == '0) && (fifo_count == '0);
    end
  end

  // Valid shift register tracking each job down the datapath pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
    end else begin
      vld[0] <= fire;
      for (int k = 1; k < LAT; k++) vld[k] <= vld[k-1];
    end
  end

  // Outstanding job count between fire and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_cnt <= '0;
    end else begin
      case ({fire, push})
        2'b10:   inflight_cnt <= inflight_cnt + IW'(1);
        2'b01:   inflight_cnt <= inflight_cnt - IW'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= gemm_out;
  end

  // Delivered-result counter, free-running modulo 2^16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     done_count <= '0;
    else if (pop) done_count <= done_count + 16'd1;
  end

endmodule

// File: tb/tb_gemm_stream_ctrl.sv
// tb_gemm_stream_ctrl: random and directed stimulus against a transaction-level
// model (job queue with availability times plus an outstanding-job credit count).
module tb_gemm_stream_ctrl;

  localparam int DW    = 32;
  localparam int N     = 2;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;
  localparam int W     = N * N * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] gemm_a;
  logic [W-1:0] gemm_b;
  logic [W-1:0] gemm_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         drain_req = 1'b0;
  logic         drain_done;
  logic         busy;
  logic [15:0]  done_count;

  typedef struct {
    logic [W-1:0] c;
    int           avail;
  } job_t;

  job_t         exp_q[$];
  int           outstanding = 0;
  int           delivered = 0;
  bit           draining = 1'b0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           m_ready;
  bit           m_ov;
  bit           m_dd;
  logic [W-1:0] dp_pipe [LAT];

  gemm_stream_ctrl #(.DW(DW), .N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .gemm_a(gemm_a), .gemm_b(gemm_b), .gemm_out(gemm_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drain_req(drain_req), .drain_done(drain_done),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  // Plain 2x2 matrix product modulo 2^DW on the packed layout.
  function automatic logic [W-1:0] matmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]  c;
    logic [DW-1:0] acc;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++)
          acc += a[(i*N+k)*DW +: DW] * b[(k*N+j)*DW +: DW];
        c[(i*N+j)*DW +: DW] = acc;
      end
    end
    return c;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the GEMM datapath: fixed LAT-cycle pipeline, never reset.
  always @(posedge clk) begin
    dp_pipe[0] <= matmul(gemm_a, gemm_b);
    for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign gemm_out = dp_pipe[LAT-1];

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Waits for the next rising edge, then drives one cycle's worth of inputs.
  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ordy, input logic dreq);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    drain_req = dreq;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, rnd_w(), rnd_w(), 1'b1, 1'b0);
      if (!busy) break;
    end
    checkOutput("idle_wait", W'(busy), W'(0));
  endtask

  // Cycle monitor: compares every output against the model, then advances the model.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      outstanding = 0;
      delivered   = 0;
      draining    = 1'b0;
      checkOutput("rst_in_ready",   W'(in_ready),   W'(0));
      checkOutput("rst_out_valid",  W'(out_valid),  W'(0));
      checkOutput("rst_busy",       W'(busy),       W'(0));
      checkOutput("rst_drain_done", W'(drain_done), W'(0));
      checkOutput("rst_done_count", W'(done_count), W'(0));
    end else begin
      m_ready = !draining && (outstanding < DEPTH);
      m_ov    = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      m_dd    = draining && (outstanding == 0);
      checkOutput("in_ready",   W'(in_ready),   W'(m_ready));
      checkOutput("out_valid",  W'(out_valid),  W'(m_ov));
      checkOutput("busy",       W'(busy),       W'(outstanding != 0));
      checkOutput("drain_done", W'(drain_done), W'(m_dd));
      checkOutput("done_count", W'(done_count), W'(16'(delivered)));
      checkOutput("gemm_a",     gemm_a,         in_a);
      checkOutput("gemm_b",     gemm_b,         in_b);
      checkOutput("fifo_bound", W'(dut.fifo_count <= DEPTH), W'(1));
      checkOutput("push_full",  W'(dut.push && (dut.fifo_count == DEPTH)), W'(0));
      if (m_ov) checkOutput("out_data", out_data, exp_q[0].c);
      if (m_ov && out_ready) begin
        void'(exp_q.pop_front());
        delivered++;
        outstanding--;
      end
      if (in_valid && m_ready) begin
        exp_q.push_back('{matmul(in_a, in_b), cyc + LAT + 1});
        outstanding++;
      end
      if (draining) begin
        if (m_dd) draining = 1'b0;
      end else if (drain_req) begin
        draining = 1'b1;
      end
    end
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    int           fires;
    int           pops;
    int           pulses;
    int           stale;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single job with known result and exact first-valid latency.
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    b = {32'd8, 32'd7, 32'd6, 32'd5};
    applyStimulus(1'b1, a, b, 1'b0, 1'b0);
    applyStimulus(1'b0, a, b, 1'b0, 1'b0);
    lat = 1;
    while (lat < 4 * LAT) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("single_latency", W'(lat), W'(LAT + 1));
    checkOutput("single_data", out_data, {32'd50, 32'd43, 32'd22, 32'd19});
    applyStimulus(1'b0, a, b, 1'b1, 1'b0);
    applyStimulus(1'b0, a, b, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("single_done_count", W'(done_count), W'(1));
    waitIdle();

    // Twenty back-to-back jobs A = k*I, B = ones: C is k everywhere, one per cycle.
    fires = 0;
    fork
      begin
        for (int k = 1; k <= 20; k++) begin
          applyStimulus(1'b1, {32'(k), 32'd0, 32'd0, 32'(k)}, {4{32'd1}}, 1'b1, 1'b0);
          @(negedge clk);
          if (in_valid && in_ready) fires++;
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      end
      begin
        int kk;
        int last_c;
        kk = 1;
        last_c = 0;
        for (int c = 0; c < 80 && kk <= 20; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            checkOutput("b2b_data", out_data, {4{32'(kk)}});
            if (kk > 1) checkOutput("b2b_gap", W'(c - last_c), W'(1));
            last_c = c;
            kk++;
          end
        end
        checkOutput("b2b_count", W'(kk - 1), W'(20));
      end
    join
    checkOutput("b2b_fires", W'(fires), W'(20));
    waitIdle();

    // Backpressure and overflow: consumer stalled for 50 offered cycles.
    fires = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, rnd_w(), rnd_w(), 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) fires++;
    end
    checkOutput("bp_accepted", W'(fires), W'(DEPTH));
    pops = 0;
    for (int i = 0; i < 100 && pops < DEPTH + 2; i++) begin
      applyStimulus(1'b0, rnd_w(), rnd_w(), 1'b1, 1'b0);
      @(negedge clk);
      if (out_valid && out_ready) pops++;
    end
    checkOutput("bp_delivered", W'(pops), W'(DEPTH));
    waitIdle();

    // Drain after three jobs, with new jobs still offered during the drain.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rnd_w(), rnd_w(), 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) applyStimulus(1'b0, rnd_w(), rnd_w(), 1'b1, 1'b1);
      else        applyStimulus(pulses == 0, rnd_w(), rnd_w(), 1'b1, pulses == 0);
      @(negedge clk);
      if (drain_done) pulses++;
    end
    checkOutput("drain_pulses", W'(pulses), W'(1));

    // drain_req held on an empty controller re-enters DRAIN every other cycle.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, rnd_w(), rnd_w(), 1'b1, 1'b1);
      @(negedge clk);
      if (drain_done) pulses++;
    end
    checkOutput("redrain_pulses", W'(pulses), W'(3));
    waitIdle();

    // Random traffic with occasional drain requests.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 4) != 0, rnd_w(), rnd_w(), ($urandom % 3) != 0,
                    ($urandom % 50) == 0);
    waitIdle();

    // Asynchronous reset mid-cycle with four jobs in flight.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, rnd_w(), rnd_w(), 1'b1, 1'b0);
    applyStimulus(1'b0, rnd_w(), rnd_w(), 1'b1, 1'b0);
    checkOutput("pre_reset_busy", W'(busy), W'(1));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_in_ready",   W'(in_ready),   W'(0));
    checkOutput("arst_out_valid",  W'(out_valid),  W'(0));
    checkOutput("arst_busy",       W'(busy),       W'(0));
    checkOutput("arst_done_count", W'(done_count), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("stale_results", W'(stale), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
